// File: rtl/weight_stream_mem.sv
// Banked weight store for one fully-connected layer: per-lane writable row RAM that streams
// one row of NUM_NEURONS weights per accepted beat, with consumer backpressure and optional looping.
module weight_stream_mem #(
  parameter int    NUM_INPUTS  = 784,
  parameter int    NUM_NEURONS = 16,
  parameter int    DATA_WIDTH  = 16,
  parameter string WEIGHT_FILE = "",
  localparam int   IDX_WIDTH   = $clog2(NUM_INPUTS),
  localparam int   NRN_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [NRN_WIDTH-1:0]              wr_neuron,
  input  logic [IDX_WIDTH-1:0]              wr_index,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_err,
  input  logic                              start,
  input  logic                              loop,
  output logic                              busy,
  output logic                              w_valid,
  input  logic                              w_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] w_data,
  output logic [IDX_WIDTH-1:0]              w_index,
  output logic                              w_last,
  output logic                              done
);

  localparam int ROW_WIDTH = NUM_NEURONS * DATA_WIDTH;
  localparam logic [IDX_WIDTH:0] NUM_ROWS  = (IDX_WIDTH+1)'(NUM_INPUTS);
  localparam logic [IDX_WIDTH:0] LAST_ROW  = (IDX_WIDTH+1)'(NUM_INPUTS - 1);
  localparam logic [IDX_WIDTH:0] PTR_ONE   = (IDX_WIDTH+1)'(1);
  localparam logic [NRN_WIDTH:0] NUM_LANES = (NRN_WIDTH+1)'(NUM_NEURONS);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH:0]   ptr_q, ptr_d;
  logic                 w_valid_q, w_valid_d;
  logic                 w_last_q, w_last_d;
  logic [IDX_WIDTH-1:0] w_index_q, w_index_d;
  logic                 done_q, done_d;
  logic                 wr_err_q, wr_err_d;
  logic                 data_ok_q, data_ok_d;
  logic [ROW_WIDTH-1:0] rd_q;

  logic                   wr_ok;
  logic                   issue;
  logic                   accept;
  logic [NUM_NEURONS-1:0] lane_we;

  logic [ROW_WIDTH-1:0] mem [NUM_INPUTS];

  // Range checks are done one bit wider so power-of-two sizes do not collapse to constants.
  assign wr_ok = wr_en && (state_q == IDLE)
              && ({1'b0, wr_index} < NUM_ROWS)
              && ({1'b0, wr_neuron} < NUM_LANES);

  generate
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_lane_we
      assign lane_we[gi] = wr_ok && (wr_neuron == NRN_WIDTH'(gi));
    end
  endgenerate

  // Storage has no reset so it maps onto block RAM and survives rst.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (lane_we[n]) mem[wr_index][n*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
    end
    if (issue) rd_q <= mem[ptr_q[IDX_WIDTH-1:0]];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    w_valid_d = w_valid_q;
    w_last_d  = w_last_q;
    w_index_d = w_index_q;
    data_ok_d = data_ok_q;
    done_d    = 1'b0;
    wr_err_d  = wr_en && !wr_ok;
    issue     = 1'b0;
    accept    = w_valid_q && w_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          ptr_d   = '0;
        end
      end
      STREAM: begin
        issue = (ptr_q < NUM_ROWS) && (!w_valid_q || w_ready);
        if (accept && w_last_q) begin
          w_valid_d = 1'b0;
          if (loop) begin
            ptr_d = '0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (issue) begin
          w_index_d = ptr_q[IDX_WIDTH-1:0];
          w_last_d  = (ptr_q == LAST_ROW);
          w_valid_d = 1'b1;
          data_ok_d = 1'b1;
          ptr_d     = ptr_q + PTR_ONE;
        end else if (accept) begin
          w_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      w_index_q <= '0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      w_valid_q <= w_valid_d;
      w_last_q  <= w_last_d;
      w_index_q <= w_index_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
      data_ok_q <= data_ok_d;
    end
  end

  // The RAM output register cannot be reset, so it is masked until the first row is read.
  assign w_data  = data_ok_q ? rd_q : '0;
  assign busy    = (state_q == STREAM);
  assign w_valid = w_valid_q;
  assign w_last  = w_last_q;
  assign w_index = w_index_q;
  assign done    = done_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_weight_stream_mem.sv
// Scoreboard bench for weight_stream_mem: 4 rows x 3 lanes; expected beats are queued at stimulus
// time and a negedge monitor pops and compares on every accepted beat.
module tb_weight_stream_mem;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [1:0]    wr_neuron;
  logic [1:0]    wr_index;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          start;
  logic          loop;
  logic          busy;
  logic          w_valid;
  logic          w_ready;
  logic [NN*DW-1:0] w_data;
  logic [1:0]    w_index;
  logic          w_last;
  logic          done;

  weight_stream_mem #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_neuron(wr_neuron), .wr_index(wr_index),
    .wr_data(wr_data), .wr_err(wr_err), .start(start), .loop(loop), .busy(busy),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_index(w_index),
    .w_last(w_last), .done(done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done_seen = 0;
  logic [63:0] exp_q[$];
  logic [47:0] exp_rows [NI];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Beat word: {last, index, row data}
  task automatic push_row(input int r);
    logic [1:0] idx;
    idx = 2'(r);
    exp_q.push_back({13'd0, (r == NI-1), idx, exp_rows[r]});
  endtask

  task automatic push_pass();
    for (int r = 0; r < NI; r++) push_row(r);
  endtask

  task automatic wr(input logic [1:0] n, input logic [1:0] i, input logic [15:0] d,
                    input logic exp_err);
    wr_en = 1'b1; wr_neuron = n; wr_index = i; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("wr_err", 64'(wr_err), 64'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic start_pass();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("lat_busy", 64'(busy), 64'd1);
    check("lat_valid_early", 64'(w_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(w_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int base);
    for (int k = 0; k < 60; k++) begin
      if (done_seen > base) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    check("done_count", 64'(done_seen - base), 64'd1);
    check("idle_after_done", 64'(busy), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops on every accepted beat and checks that stalled beats hold still.
  initial begin
    logic        prev_stall;
    logic [50:0] prev_beat;
    logic [63:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {12'd0, w_valid, w_last, w_index, w_data}, {12'd0, 1'b1, prev_beat});
        if (w_valid && w_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("beat", {13'd0, w_last, w_index, w_data}, e);
            $display("beat idx=%0d last=%0d data=%h", w_index, w_last, w_data);
          end
        end
        prev_stall = w_valid && !w_ready;
        prev_beat  = {w_last, w_index, w_data};
        if (done) done_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    exp_rows[0] = 48'h0020_0010_0001;
    exp_rows[1] = 48'h0021_0011_0002;
    exp_rows[2] = 48'h0022_0012_0003;
    exp_rows[3] = 48'h0023_0013_0004;

    rst = 1'b1; start = 1'b1; loop = 1'b0; w_ready = 1'b0;
    wr_en = 1'b0; wr_neuron = '0; wr_index = '0; wr_data = '0;

    // Reset with start held high: everything quiet, no pass afterwards.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(w_valid), 64'd0);
    check("rst_last", 64'(w_last), 64'd0);
    check("rst_index", 64'(w_index), 64'd0);
    check("rst_data", 64'(w_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("no_pass_after_rst", 64'(busy), 64'd0);
    check("no_valid_after_rst", 64'(w_valid), 64'd0);
    @(posedge clk); #1;

    // Load all lanes.
    for (int r = 0; r < NI; r++) begin
      wr(2'd0, 2'(r), 16'(r + 1), 1'b0);
      wr(2'd1, 2'(r), 16'(16 + r), 1'b0);
      wr(2'd2, 2'(r), 16'(32 + r), 1'b0);
    end

    // Plain stream at full throughput.
    base = done_seen;
    w_ready = 1'b1;
    push_pass();
    start_pass();
    wait_done(base);

    // Backpressure on several cycles.
    base = done_seen;
    w_ready = 1'b0;
    push_pass();
    start_pass();
    repeat (2) begin @(posedge clk); #1; end
    w_ready = 1'b1;
    @(posedge clk); #1;
    w_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    w_ready = 1'b1;
    wait_done(base);

    // Loop once, then finish.
    base = done_seen;
    loop = 1'b1;
    push_pass();
    push_pass();
    start_pass();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (w_valid && w_ready && w_last) break;
    end
    @(posedge clk); #1;
    loop = 1'b0;
    @(negedge clk);
    check("loop_bubble", 64'(w_valid), 64'd0);
    check("loop_busy", 64'(busy), 64'd1);
    check("loop_no_done", 64'(done_seen - base), 64'd0);
    @(posedge clk); #1;
    wait_done(base);

    // Dropped writes: during busy, and to a lane that does not exist. wr_index is only
    // two bits at four rows, so the out-of-range path is reached through the lane select.
    base = done_seen;
    push_pass();
    start_pass();
    wr(2'd0, 2'd1, 16'hBEEF, 1'b1);
    wait_done(base);
    wr(2'd3, 2'd2, 16'hDEAD, 1'b1);
    @(negedge clk);
    check("wr_err_pulse", 64'(wr_err), 64'd0);
    @(posedge clk); #1;
    base = done_seen;
    push_pass();
    start_pass();
    wait_done(base);

    // Abort after beat 1 is accepted, then replay from row 0.
    base = done_seen;
    push_row(0);
    push_row(1);
    start_pass();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_valid", 64'(w_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_done", 64'(done_seen - base), 64'd0);
    push_pass();
    start_pass();
    wait_done(base);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
